// File: rtl/ntt_ctrl.sv
// ntt_ctrl: address and control sequencer for an in-place radix-2 Cooley-Tukey forward NTT.
// Define NTT_CTRL_PERF_CNT_EN to add the cyc_cnt busy-cycle counter output.
module ntt_ctrl #(
    parameter int N_LOG2 = 8,
    parameter int W      = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_LOG2-1:0] ra0,
    output logic [N_LOG2-1:0] ra1,
    input  logic [W-1:0]      rd0,
    input  logic [W-1:0]      rd1,
    output logic [N_LOG2-1:0] tf_addr,
    input  logic [W-1:0]      tf_data,
    output logic [W-1:0]      bu_x,
    output logic [W-1:0]      bu_y,
    output logic [W-1:0]      bu_tf,
    input  logic [W-1:0]      bu_a,
    input  logic [W-1:0]      bu_b,
    output logic              we,
    output logic [N_LOG2-1:0] wa0,
    output logic [N_LOG2-1:0] wa1,
    output logic [W-1:0]      wd0,
    output logic [W-1:0]      wd1,
    output logic [1:0]        dbg_state
`ifdef NTT_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]       cyc_cnt
`endif
);

    localparam int PW = N_LOG2 - 1;
    localparam int SW = (N_LOG2 > 1) ? $clog2(N_LOG2 + 1) : 1;
    localparam logic [N_LOG2-1:0] ONE = N_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     pair;
    logic [SW-1:0]     stage;
    logic              drain_cnt;
    logic              last_pair;
    logic              last_stage;

    logic [SW-1:0]     shamt;
    logic [N_LOG2-1:0] pair_ext;
    logic [N_LOG2-1:0] len_v;
    logic [N_LOG2-1:0] grp;
    logic [N_LOG2-1:0] off;
    logic [N_LOG2-1:0] j_v;

    logic              v1;
    logic              v2;
    logic [N_LOG2-1:0] a1_0;
    logic [N_LOG2-1:0] a1_1;

    assign last_pair  = &pair;
    assign last_stage = (stage == SW'(N_LOG2 - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_pair) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = last_stage ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // pair wraps to 0 on the last issue of a stage, so RUN always restarts at p=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair      <= '0;
            stage     <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    pair      <= pair + PW'(1);
                    drain_cnt <= 1'b0;
                end
                DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) stage <= stage + SW'(1);
                end
                default: begin
                    pair      <= '0;
                    stage     <= '0;
                    drain_cnt <= 1'b0;
                end
            endcase
        end
    end

    // len = N>>(s+1) = 1<<shamt, group g = p>>shamt, j = g*2*len + (p mod len)
    always_comb begin
        shamt    = SW'(N_LOG2 - 1) - stage;
        pair_ext = {1'b0, pair};
        len_v    = ONE << shamt;
        grp      = pair_ext >> shamt;
        off      = pair_ext & (len_v - ONE);
        j_v      = ((grp << shamt) << 1) + off;
        ra0      = '0;
        ra1      = '0;
        tf_addr  = '0;
        if (state == RUN) begin
            ra0     = j_v;
            ra1     = j_v + len_v;
            tf_addr = (ONE << stage) + grp;
        end
    end

    // Write-back stream: we is the valid of the write stage and carries no ready,
    // the RAM accepts every beat; wa0/wa1 are the read addresses from two cycles earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            a1_0 <= '0;
            a1_1 <= '0;
            wa0  <= '0;
            wa1  <= '0;
        end else begin
            v1   <= (state == RUN);
            a1_0 <= ra0;
            a1_1 <= ra1;
            v2   <= v1;
            wa0  <= a1_0;
            wa1  <= a1_1;
        end
    end

    assign we        = v2;
    assign wd0       = bu_a;
    assign wd1       = bu_b;
    assign bu_x      = rd0;
    assign bu_y      = rd1;
    assign bu_tf     = tf_data;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign dbg_state = state;

`ifdef NTT_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            cyc_cnt <= '0;
        end else if (busy) begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: ntt_ctrl with a read-before-write RAM, Dilithium twiddle ROM and registered butterfly;
// write addresses and final coefficients are scoreboarded against a software NTT.
module tb_ntt_ctrl;
    localparam int N       = 256;
    localparam int W       = 23;
    localparam int Q       = 8380417;
    localparam int RUN_CYC = 1040;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [7:0]   ra0;
    logic [7:0]   ra1;
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    logic [7:0]   tf_addr;
    logic [W-1:0] tf_data;
    logic [W-1:0] bu_x;
    logic [W-1:0] bu_y;
    logic [W-1:0] bu_tf;
    logic [W-1:0] bu_a;
    logic [W-1:0] bu_b;
    logic         we;
    logic [7:0]   wa0;
    logic [7:0]   wa1;
    logic [W-1:0] wd0;
    logic [W-1:0] wd1;
    logic [1:0]   dbg_state;
`ifdef NTT_CTRL_PERF_CNT_EN
    logic [15:0]  cyc_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0]  exp_q[$];
    logic [W-1:0] coef_q[$];
    logic [15:0]  exp_w;
    logic [W-1:0] mem[N];
    logic [W-1:0] rom[N];
    logic         pl_we;
    logic [7:0]   pl_addr;
    logic [W-1:0] pl_data;

    ntt_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
        .tf_addr(tf_addr), .tf_data(tf_data),
        .bu_x(bu_x), .bu_y(bu_y), .bu_tf(bu_tf), .bu_a(bu_a), .bu_b(bu_b),
        .we(we), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .dbg_state(dbg_state)
`ifdef NTT_CTRL_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd0     <= mem[ra0];
        rd1     <= mem[ra1];
        tf_data <= rom[tf_addr];
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (we) begin
            mem[wa0] <= wd0;
            mem[wa1] <= wd1;
        end
    end

    always @(posedge clk) begin
        longint t;
        t = (longint'(bu_tf) * longint'(bu_y)) % Q;
        bu_a <= W'((longint'(bu_x) + t) % Q);
        bu_b <= W'((longint'(bu_x) + Q - t) % Q);
    end

    always @(negedge clk) begin
        if (we === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got wa0=%0d wa1=%0d, required no write", wa0, wa1);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wa0, wa1} !== exp_w)
                    $display("FAIL write_addr: got wa0=%0d wa1=%0d, required wa0=%0d wa1=%0d",
                             wa0, wa1, exp_w[15:8], exp_w[7:0]);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_rom();
        logic [7:0] kk;
        logic [7:0] br;
        longint     z;
        for (int k = 0; k < N; k++) begin
            kk = 8'(k);
            for (int b = 0; b < 8; b++) br[b] = kk[7-b];
            z = 1;
            for (int e = 0; e < int'(br); e++) z = (z * 1753) % Q;
            rom[k] = W'(z);
        end
    endtask

    task automatic preload(input bit random_data);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = 8'(i);
            if (random_data) pl_data = W'($urandom_range(0, Q - 1));
            else             pl_data = (i == 0) ? W'(1) : W'(0);
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic compute_ref();
        longint a[N];
        longint t;
        longint z;
        int     k;
        for (int i = 0; i < N; i++) a[i] = longint'(mem[i]);
        k = 0;
        for (int len = N / 2; len > 0; len = len / 2) begin
            for (int st = 0; st < N; st += 2 * len) begin
                k++;
                z = longint'(rom[k]);
                for (int j = st; j < st + len; j++) begin
                    t        = (z * a[j+len]) % Q;
                    a[j+len] = (a[j] + Q - t) % Q;
                    a[j]     = (a[j] + t) % Q;
                end
            end
        end
        for (int i = 0; i < N; i++) coef_q.push_back(W'(a[i]));
    endtask

    task automatic push_writes();
        for (int len = N / 2; len > 0; len = len / 2)
            for (int st = 0; st < N; st += 2 * len)
                for (int j = st; j < st + len; j++)
                    exp_q.push_back({8'(j), 8'(j + len)});
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Advances from cycle k0 (relative to first RUN cycle) until done or a cycle budget expires.
    task automatic run_to_done(input int k0, input int pulse_at, output int done_at,
                               output logic [23:0] last_issue, output logic [24:0] drain_snap);
        int k;
        k          = k0;
        done_at    = -1;
        last_issue = '0;
        drain_snap = '0;
        while (k < 1200 && done_at < 0) begin
            @(negedge clk);
            k++;
            start = (k == pulse_at);
            if (k == 7 * 130 + 127) last_issue = {ra0, ra1, tf_addr};
            if (k == 128) drain_snap = {busy, ra0, ra1, tf_addr};
            if (done === 1'b1) done_at = k;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else pass_cnt++;
        total_cnt++; if (we !== 1'b0) $display("FAIL reset_we: got %b required 0", we); else pass_cnt++;
        total_cnt++; if ({ra0, ra1, tf_addr} !== 24'd0) $display("FAIL reset_raddr: got %0d %0d %0d required 0 0 0", ra0, ra1, tf_addr); else pass_cnt++;
        total_cnt++; if ({wa0, wa1} !== 16'd0) $display("FAIL reset_waddr: got %0d %0d required 0 0", wa0, wa1); else pass_cnt++;
        total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d required 0", dbg_state); else pass_cnt++;
`ifdef NTT_CTRL_PERF_CNT_EN
        total_cnt++; if (cyc_cnt !== 16'd0) $display("FAIL reset_cyc_cnt: got %0d required 0", cyc_cnt); else pass_cnt++;
`endif
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_no_start: got busy=%b required 0", busy); else pass_cnt++;
    endtask

    task automatic test_impulse();
        int           done_at;
        logic [23:0]  last_issue;
        logic [24:0]  drain_snap;
        logic [W-1:0] exp_c;
        int           not_one;
        preload(1'b0);
        compute_ref();
        push_writes();
        launch();
        total_cnt++; if ({ra0, ra1, tf_addr} !== {8'd0, 8'd128, 8'd1}) $display("FAIL first_issue: got %0d %0d %0d required 0 128 1", ra0, ra1, tf_addr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL first_busy: got %b required 1", busy); else pass_cnt++;
        total_cnt++; if (dbg_state !== 2'd1) $display("FAIL first_state: got %0d required 1", dbg_state); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (we !== 1'b0) $display("FAIL cycle1_we: got %b required 0", we); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({we, wa0, wa1} !== {1'b1, 8'd0, 8'd128}) $display("FAIL first_write: got we=%b wa0=%0d wa1=%0d required 1 0 128", we, wa0, wa1); else pass_cnt++;
        run_to_done(2, -1, done_at, last_issue, drain_snap);
        total_cnt++; if (done_at !== RUN_CYC) $display("FAIL impulse_done_cycle: got %0d required %0d", done_at, RUN_CYC); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL done_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (last_issue !== {8'd254, 8'd255, 8'd255}) $display("FAIL last_issue: got %0d %0d %0d required 254 255 255", last_issue[23:16], last_issue[15:8], last_issue[7:0]); else pass_cnt++;
        total_cnt++; if (drain_snap !== {1'b1, 24'd0}) $display("FAIL drain_outputs: got busy=%b addr=%h required busy=1 addr=0", drain_snap[24], drain_snap[23:0]); else pass_cnt++;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL impulse_write_count: got %0d missing writes required 0", exp_q.size()); else pass_cnt++;
`ifdef NTT_CTRL_PERF_CNT_EN
        total_cnt++; if (cyc_cnt !== 16'd1040) $display("FAIL cyc_cnt_done: got %0d required 1040", cyc_cnt); else pass_cnt++;
`endif
        not_one = 0;
        for (int i = 0; i < N; i++) begin
            exp_c = coef_q.pop_front();
            if (mem[i] !== W'(1)) not_one++;
            total_cnt++;
            if (mem[i] !== exp_c) $display("FAIL impulse_coef[%0d]: got %0d required %0d", i, mem[i], exp_c); else pass_cnt++;
        end
        total_cnt++; if (not_one != 0) $display("FAIL impulse_all_ones: got %0d coefficients not 1 required 0", not_one); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({done, dbg_state} !== {1'b0, 2'd0}) $display("FAIL done_pulse_width: got done=%b state=%0d required 0 0", done, dbg_state); else pass_cnt++;
    endtask

    task automatic test_random_start_ignored();
        int           done_at;
        logic [23:0]  last_issue;
        logic [24:0]  drain_snap;
        logic [W-1:0] exp_c;
        preload(1'b1);
        compute_ref();
        push_writes();
        launch();
`ifdef NTT_CTRL_PERF_CNT_EN
        total_cnt++; if (cyc_cnt !== 16'd0) $display("FAIL cyc_cnt_clear: got %0d required 0", cyc_cnt); else pass_cnt++;
`endif
        run_to_done(0, 500, done_at, last_issue, drain_snap);
        total_cnt++; if (done_at !== RUN_CYC) $display("FAIL busy_start_done_cycle: got %0d required %0d", done_at, RUN_CYC); else pass_cnt++;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL random_write_count: got %0d missing writes required 0", exp_q.size()); else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            exp_c = coef_q.pop_front();
            total_cnt++;
            if (mem[i] !== exp_c) $display("FAIL random_coef[%0d]: got %0d required %0d", i, mem[i], exp_c); else pass_cnt++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if ({busy, dbg_state} !== {1'b0, 2'd0}) $display("FAIL done_start_ignored: got busy=%b state=%0d required 0 0", busy, dbg_state); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL done_start_stays_idle: got busy=%b required 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int           done_at;
        logic [23:0]  last_issue;
        logic [24:0]  drain_snap;
        logic [W-1:0] exp_c;
        push_writes();
        launch();
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (we !== 1'b0) $display("FAIL midrst_we: got %b required 0", we); else pass_cnt++;
        total_cnt++; if ({ra0, ra1, tf_addr, dbg_state} !== 26'd0) $display("FAIL midrst_addr_state: got %0d %0d %0d state=%0d required 0", ra0, ra1, tf_addr, dbg_state); else pass_cnt++;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        compute_ref();
        push_writes();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if ({busy, ra0, ra1} !== {1'b1, 8'd0, 8'd128}) $display("FAIL restart_first: got busy=%b ra0=%0d ra1=%0d required 1 0 128", busy, ra0, ra1); else pass_cnt++;
        run_to_done(0, -1, done_at, last_issue, drain_snap);
        total_cnt++; if (done_at !== RUN_CYC) $display("FAIL restart_done_cycle: got %0d required %0d", done_at, RUN_CYC); else pass_cnt++;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL restart_write_count: got %0d missing writes required 0", exp_q.size()); else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            exp_c = coef_q.pop_front();
            total_cnt++;
            if (mem[i] !== exp_c) $display("FAIL restart_coef[%0d]: got %0d required %0d", i, mem[i], exp_c); else pass_cnt++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pl_we   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        init_rom();
        test_reset();
        test_impulse();
        test_random_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameter N_LOG2, default 8; log2 of polynomial length N (N=256 by default, stages = N_LOG2, pairs per stage = N/2).
REQ-002 SHALL have parameter W, default 23; coefficient/twiddle width (mod Q=8380417).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin forward NTT; sampled only in IDLE.
REQ-006 busy  output  1  high while a transform is in progress.
REQ-007 done  output  1  one-cycle pulse after the final write-back.
REQ-008 ra0, ra1  output  N_LOG2 each  coefficient RAM read addresses (even/odd operand).
REQ-009 rd0, rd1  input  W each  RAM read data, valid one cycle after the address.
REQ-010 tf_addr  output  N_LOG2  twiddle ROM address; tf_data  input  W  valid one cycle later.
REQ-011 bu_x, bu_y, bu_tf  output  W each  butterfly operands (rd0, rd1, tf_data, passed combinationally).
REQ-012 bu_a, bu_b  input  W each  butterfly results, valid two cycles after issue (1-cycle RAM + 1 register stage in butterfly).
REQ-013 we  output  1; wa0, wa1  output  N_LOG2; wd0, wd1  output  W  RAM write port (wd0=bu_a to wa0, wd1=bu_b to wa1).

Function
REQ-014 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after the 128th (N/2-th) issue of a stage; DRAIN lasts exactly 2 cycles, then RUN for the next stage, or DONE after stage N_LOG2-1; DONE->IDLE after 1 cycle.
REQ-015 Stage s (0..N_LOG2-1): len = N>>(s+1); pair counter p = 0..N/2-1; group g = p>>(N_LOG2-1-s); off = p mod len; j = g*2*len + off.
REQ-016 Each RUN cycle SHALL issue ra0=j, ra1=j+len, tf_addr=(1<<s)+g (Cooley-Tukey order, twiddle index 1..N-1).
REQ-017 Issue addresses ra0/ra1 SHALL be delayed through a 2-deep pipeline with a valid bit; we=1 with wa0/wa1 equal to the addresses issued exactly 2 cycles earlier, and we=0 otherwise.
REQ-018 The RAM SHALL be read-before-write; the 2-cycle DRAIN guarantees no stage reads data the previous stage has not yet written.
REQ-019 busy SHALL be high from the first RUN cycle through the last DRAIN cycle; done high only in DONE; busy=0 in DONE.
REQ-020 Total: first RUN cycle to last write = 8*(128+2) = 1040 cycles (default); done in cycle 1041.
REQ-021 start while busy or in DONE SHALL be ignored.
REQ-022 In IDLE/DRAIN, ra0, ra1, tf_addr SHALL be 0 and no new issue valid entered into the pipeline.

Reset
REQ-023 On rst: state=IDLE, stage/pair counters=0, pipeline valids=0, we=0, busy=0, done=0, all address outputs 0; takes effect immediately, including mid-transform (RAM contents then undefined; no further writes).
REQ-024 After rst deasserts, the block SHALL accept start on the next rising edge.

Configuration
REQ-025 Macro NTT_CTRL_PERF_CNT_EN: when defined, an output cyc_cnt [15:0] SHALL count busy cycles of the current/last transform, clear on start acceptance, hold after done, reset to 0; when undefined the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-026 First RUN cycle after start -> ra0=0, ra1=128, tf_addr=1; two cycles later we=1, wa0=0, wa1=128.
REQ-027 Last RUN cycle of stage 7 -> ra0=254, ra1=255, tf_addr=255; done pulses exactly 1040 cycles after the first RUN cycle.
REQ-028 RAM preloaded with a[0]=1, others 0, butterfly + Dilithium zeta ROM attached -> all 256 coefficients equal 1 after done.
REQ-029 Random polynomial -> RAM contents after done match software reference NTT mod 8380417 bit-exactly.
REQ-030 start pulsed at cycle 500 of a transform -> ignored, done timing unchanged; rst at cycle 300 -> busy=0, we=0 immediately, new start then completes normally.
REQ-031 With NTT_CTRL_PERF_CNT_EN defined -> cyc_cnt=1040 after done, 0 following the next accepted start edge.
